// File: rtl/line_pkg.sv
// Shared types and screen constants for the line rasteriser.
package line_pkg;

    localparam int X_W_DEFAULT = 10;
    localparam int Y_W_DEFAULT = 9;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } line_state_t;

endpackage

// File: rtl/line_setup.sv
// Combinational octant normaliser: folds any line onto a left-to-right walk
// along its major axis with a +/-1 minor step.
module line_setup #(
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int C_W = 11
) (
    input  logic [X_W-1:0]        x0,
    input  logic [Y_W-1:0]        y0,
    input  logic [X_W-1:0]        x1,
    input  logic [Y_W-1:0]        y1,
    output logic                  steep,
    output logic signed [C_W-1:0] major_start,
    output logic signed [C_W-1:0] minor_start,
    output logic signed [C_W-1:0] major_end,
    output logic signed [C_W-1:0] dx,
    output logic signed [C_W-1:0] dy,
    output logic signed [C_W-1:0] step
);

    logic signed [C_W-1:0] sx0, sy0, sx1, sy1;
    logic signed [C_W-1:0] abs_dx, abs_dy;
    logic signed [C_W-1:0] a0, b0, a1, b1;
    logic signed [C_W-1:0] minor_end;

    always_comb begin
        sx0 = C_W'(x0);
        sy0 = C_W'(y0);
        sx1 = C_W'(x1);
        sy1 = C_W'(y1);

        abs_dx = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
        abs_dy = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
        steep  = abs_dy > abs_dx;

        // a = major axis, b = minor axis
        if (steep) begin
            a0 = sy0; b0 = sx0; a1 = sy1; b1 = sx1;
        end else begin
            a0 = sx0; b0 = sy0; a1 = sx1; b1 = sy1;
        end

        if (a0 > a1) begin
            major_start = a1; minor_start = b1;
            major_end   = a0; minor_end   = b0;
        end else begin
            major_start = a0; minor_start = b0;
            major_end   = a1; minor_end   = b1;
        end

        dx   = major_end - major_start;
        dy   = (minor_end >= minor_start) ? minor_end - minor_start
                                          : minor_start - minor_end;
        step = (minor_end > minor_start) ? C_W'(1) : {C_W{1'b1}};
    end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one framebuffer pixel write per clock, then a
// one-cycle done pulse. Abort and reset cancel a line without done.
module line_raster_engine
    import line_pkg::*;
#(
    parameter int X_W = X_W_DEFAULT,
    parameter int Y_W = Y_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic           color_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_color,
    output logic           pixel_valid
);

    // One bit of headroom over the widest coordinate keeps the error term signed.
    localparam int C_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic signed [C_W-1:0] ONE = C_W'(1);

    line_state_t state_reg, state_next;

    logic [X_W-1:0] x0_reg, x1_reg;
    logic [Y_W-1:0] y0_reg, y1_reg;
    logic           color_reg;

    logic                  steep_reg;
    logic signed [C_W-1:0] major_reg, minor_reg, major_end_reg;
    logic signed [C_W-1:0] dx_reg, dy_reg, step_reg, err_reg;
    logic [X_W-1:0]        x_reg;
    logic [Y_W-1:0]        y_reg;

    logic                  s_steep;
    logic signed [C_W-1:0] s_major_start, s_minor_start, s_major_end;
    logic signed [C_W-1:0] s_dx, s_dy, s_step;

    logic                  cmd_accept;
    logic                  last_pixel;
    logic signed [C_W-1:0] err_sub, err_next, minor_next, major_next;

    line_setup #(
        .X_W(X_W),
        .Y_W(Y_W),
        .C_W(C_W)
    ) u_setup (
        .x0         (x0_reg),
        .y0         (y0_reg),
        .x1         (x1_reg),
        .y1         (y1_reg),
        .steep      (s_steep),
        .major_start(s_major_start),
        .minor_start(s_minor_start),
        .major_end  (s_major_end),
        .dx         (s_dx),
        .dy         (s_dy),
        .step       (s_step)
    );

    assign cmd_accept = start && !abort;
    assign last_pixel = (major_reg == major_end_reg);

    always_comb begin
        err_sub    = err_reg - dy_reg;
        major_next = major_reg + ONE;
        if (err_sub < 0) begin
            minor_next = minor_reg + step_reg;
            err_next   = err_sub + dx_reg;
        end else begin
            minor_next = minor_reg;
            err_next   = err_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (cmd_accept) state_next = SETUP;
            SETUP:   state_next = abort ? IDLE : DRAW;
            DRAW: begin
                if (abort)           state_next = IDLE;
                else if (last_pixel) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_reg        <= '0;
            y0_reg        <= '0;
            x1_reg        <= '0;
            y1_reg        <= '0;
            color_reg     <= 1'b0;
            steep_reg     <= 1'b0;
            major_reg     <= '0;
            minor_reg     <= '0;
            major_end_reg <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            step_reg      <= '0;
            err_reg       <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (cmd_accept) begin
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        x1_reg    <= x1;
                        y1_reg    <= y1;
                        color_reg <= color_in;
                    end
                end
                SETUP: begin
                    steep_reg     <= s_steep;
                    major_reg     <= s_major_start;
                    minor_reg     <= s_minor_start;
                    major_end_reg <= s_major_end;
                    dx_reg        <= s_dx;
                    dy_reg        <= s_dy;
                    step_reg      <= s_step;
                    err_reg       <= s_dx >>> 1;
                    // First pixel must already sit on x/y when DRAW begins.
                    x_reg <= s_steep ? s_minor_start[X_W-1:0] : s_major_start[X_W-1:0];
                    y_reg <= s_steep ? s_major_start[Y_W-1:0] : s_minor_start[Y_W-1:0];
                end
                DRAW: begin
                    if (!last_pixel) begin
                        major_reg <= major_next;
                        minor_reg <= minor_next;
                        err_reg   <= err_next;
                        x_reg <= steep_reg ? minor_next[X_W-1:0] : major_next[X_W-1:0];
                        y_reg <= steep_reg ? major_next[Y_W-1:0] : minor_next[Y_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign pixel_valid = (state_reg == DRAW);
    assign x           = x_reg;
    assign y           = y_reg;
    assign pixel_color = color_reg;

endmodule

// File: tb/tb_line_raster_engine.sv
// Scoreboard bench for line_raster_engine: a closed-form line model queues
// expected pixel/done events; a negedge monitor checks what the DUT emits.
module tb_line_raster_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] x0 = '0, x1 = '0;
    logic [8:0] y0 = '0, y1 = '0;
    logic       color_in = 1'b0;
    logic       busy, done, pixel_color, pixel_valid;
    logic [9:0] x;
    logic [8:0] y;

    line_raster_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .color_in   (color_in),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .pixel_color(pixel_color),
        .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int px;
        int py;
        bit c;
        int at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Closed form of Bresenham: after k major steps the minor offset is the
    // smallest m keeping (dx/2 - k*dy + m*dx) non-negative.
    function automatic void push_expected(input int ax0, input int ay0, input int ax1,
                                          input int ay1, input bit c, input int s,
                                          input int limit, input bit with_done);
        int adx, ady, a0, b0, a1, b1, t, dmaj, dmin, dir, h, n, m, mn;
        bit steep;
        exp_t e;
        adx   = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady   = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        steep = ady > adx;
        if (steep) begin a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1; end
        else       begin a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1; end
        if (a0 > a1) begin
            t = a0; a0 = a1; a1 = t;
            t = b0; b0 = b1; b1 = t;
        end
        dmaj = a1 - a0;
        dmin = (b1 > b0) ? b1 - b0 : b0 - b1;
        dir  = (b1 > b0) ? 1 : -1;
        h    = dmaj / 2;
        for (int k = 0; k <= dmaj && k < limit; k++) begin
            n  = k * dmin - h;
            m  = (n <= 0) ? 0 : (n + dmaj - 1) / dmaj;
            mn = b0 + dir * m;
            e.is_done = 1'b0;
            e.px = steep ? mn : a0 + k;
            e.py = steep ? a0 + k : mn;
            e.c  = c;
            e.at = s + 2 + k;
            q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.px = 0; e.py = 0; e.c = c;
            e.at = s + 3 + dmaj;
            q.push_back(e);
        end
    endfunction

    function automatic int line_len(input int ax0, input int ay0, input int ax1, input int ay1);
        int adx, ady;
        adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        return ((adx > ady) ? adx : ady) + 1;
    endfunction

    // Monitor: every pixel_valid or done cycle must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pixel_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL pixel_unexpected: got (%0d,%0d) at cyc %0d, required no pixel", x, y, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.is_done || int'(x) != e.px || int'(y) != e.py ||
                        pixel_color != e.c || cyc != e.at || !busy) begin
                        fails++;
                        $display("FAIL pixel: got (%0d,%0d) c=%0d busy=%0d cyc=%0d, required %s (%0d,%0d) c=%0d busy=1 cyc=%0d",
                                 x, y, pixel_color, busy, cyc, e.is_done ? "done" : "pixel",
                                 e.px, e.py, e.c, e.at);
                    end
                end
            end
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got done at cyc %0d, required none", cyc);
                end else begin
                    e = q.pop_front();
                    if (!e.is_done || cyc != e.at || !busy || pixel_valid) begin
                        fails++;
                        $display("FAIL done: got done at cyc %0d busy=%0d pv=%0d, required %s at cyc %0d busy=1 pv=0",
                                 cyc, busy, pixel_valid, e.is_done ? "done" : "pixel", e.at);
                    end
                end
            end
        end
    end

    task automatic check_idle(input string tag, input bit full);
        tests++;
        if (busy || done || pixel_valid ||
            (full && (x != 0 || y != 0 || pixel_color))) begin
            fails++;
            $display("FAIL %s: got busy=%0d done=%0d pv=%0d x=%0d y=%0d c=%0d, required all 0%s",
                     tag, busy, done, pixel_valid, x, y, pixel_color,
                     full ? "" : " (busy/done/pv)");
        end
    endtask

    // mode: 0 normal, 1 start pulse mid-DRAW, 2 abort at pixel p, 3 reset at pixel p,
    // 4 start and abort together. Called at a negedge.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input bit c, input int mode, input int p);
        int n, s, lim;
        bit wd;
        n   = line_len(ax0, ay0, ax1, ay1);
        lim = (mode >= 2) ? ((mode == 4) ? 0 : p) : n;
        wd  = (mode <= 1);
        x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
        color_in = c;
        start = 1'b1;
        abort = (mode == 4);
        s = cyc;
        push_expected(ax0, ay0, ax1, ay1, c, s, lim, wd);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        x0 = 10'($urandom_range(0, 639)); y0 = 9'($urandom_range(0, 479));
        x1 = 10'($urandom_range(0, 639)); y1 = 9'($urandom_range(0, 479));
        color_in = ~c;
        case (mode)
            0, 1: begin
                if (mode == 1) begin
                    repeat (3) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    repeat (n - 3) @(negedge clk);
                end else begin
                    repeat (n + 1) @(negedge clk);
                end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_idle("idle_after_done", 1'b0);
            end
            2, 3: begin
                repeat (p) @(negedge clk);
                if (mode == 2) abort = 1'b1;
                else           reset = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                reset = 1'b0;
                check_idle(mode == 2 ? "idle_after_abort" : "outputs_after_reset", mode == 3);
            end
            default: check_idle("start_with_abort_dropped", 1'b0);
        endcase
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL events_left: got %0d unconsumed events, required 0", q.size());
            q.delete();
        end
        $display("[TB] cmd (%0d,%0d)->(%0d,%0d) c=%0d mode=%0d p=%0d len=%0d at cyc %0d",
                 ax0, ay0, ax1, ay1, c, mode, p, n, s);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time budget at cyc %0d, required finish", cyc);
        $fatal(1);
    end

    initial begin
        int ax0, ay0, ax1, ay1, n, mode;
        repeat (3) @(negedge clk);
        check_idle("reset_state", 1'b1);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_cmd(200, 10, 200, 200, 1'b1, 0, 0);
        run_cmd(0, 0, 4, 2, 1'b1, 0, 0);
        run_cmd(295, 364, 200, 200, 1'b0, 0, 0);
        run_cmd(35, 105, 35, 105, 1'b1, 0, 0);
        run_cmd(0, 0, 9, 0, 1'b1, 1, 0);
        run_cmd(0, 0, 9, 0, 1'b1, 2, 4);
        run_cmd(10, 20, 300, 100, 1'b1, 3, 7);
        run_cmd(600, 470, 5, 3, 1'b1, 0, 0);
        run_cmd(100, 100, 150, 120, 1'b1, 4, 0);
        run_cmd(100, 100, 150, 120, 1'b0, 2, 0);
        run_cmd(639, 479, 0, 0, 1'b1, 0, 0);
        run_cmd(0, 479, 639, 0, 1'b0, 0, 0);
        run_cmd(320, 240, 320, 240, 1'b1, 2, 1);

        for (int i = 0; i < 24; i++) begin
            ax0 = $urandom_range(0, 639); ay0 = $urandom_range(0, 479);
            ax1 = $urandom_range(0, 639); ay1 = $urandom_range(0, 479);
            n    = line_len(ax0, ay0, ax1, ay1);
            mode = $urandom_range(0, 5);
            if (mode >= 4) mode = 0;
            if (mode == 1 && n < 5) mode = 0;
            run_cmd(ax0, ay0, ax1, ay1, 1'($urandom_range(0, 1)), mode,
                    $urandom_range(1, n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
